param_usr: RTL and testbench

PARAM_USR -- requirements
Module: param_usr

---
 rtl/param_usr.sv | 81 ++++++++
 tb/tb_param_usr.sv | 138 +++++++++++++
 2 files changed

// File: rtl/param_usr.sv
// param_usr: universal shift register with single-cycle ops and a counted shift burst.
// Ports: clk, reset (async active-low); en/mode/din/sinl/sinr drive single ops in IDLE;
// start/nshift launch a burst of the selected shift mode; q with soutl/soutr taps;
// busy during burst and done, done for the single cycle after the last shift.
module param_usr #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sinl,
  input  logic             sinr,
  input  logic             start,
  input  logic [CNTW-1:0]  nshift,
  output logic [WIDTH-1:0] q,
  output logic             soutl,
  output logic             soutr,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BURST = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;
  localparam logic [CNTW-1:0] WMAX = CNTW'(WIDTH);
  logic [1:0]       state;
  logic [2:0]       lmode;
  logic [CNTW-1:0]  cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] nxt;
  logic             is_shift;
  logic [CNTW-1:0]  cnt_init;
  assign soutl = q[WIDTH-1];
  assign soutr = q[0];
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign is_shift = mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
  assign cnt_init = nshift > WMAX ? WMAX : nshift;
  // During a burst the latched mode drives the datapath; in IDLE the live mode does.
  assign op = state == BURST ? lmode : mode;
  always_comb begin
    nxt = q;
    case (op)
      3'b000:  nxt = din;
      3'b001:  nxt = {q[WIDTH-2:0], sinl};
      3'b010:  nxt = {sinr, q[WIDTH-1:1]};
      3'b100:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b101:  nxt = {q[0], q[WIDTH-1:1]};
      3'b110:  nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      default: nxt = q;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lmode <= 3'b011;
      cnt   <= '0;
      q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && is_shift) begin
            lmode <= mode;
            cnt   <= cnt_init;
            state <= cnt_init != '0 ? BURST : DONE;
          end else if (en) begin
            q <= nxt;
          end
        end
        BURST: begin
          q   <= nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_usr.sv
// tb_param_usr: directed scoreboard bench for param_usr at WIDTH=8.
module tb_param_usr;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b011;
  logic [7:0] din = '0;
  logic       sinl = 1'b0;
  logic       sinr = 1'b0;
  logic       start = 1'b0;
  logic [3:0] nshift = '0;
  logic [7:0] q;
  logic       soutl, soutr, busy, done;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  param_usr #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din),
    .sinl(sinl), .sinr(sinr), .start(start), .nshift(nshift),
    .q(q), .soutl(soutl), .soutr(soutr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected q is queued with the stimulus and compared after the edge.
  task automatic step(input string tag, input logic [7:0] v);
    logic [7:0] e;
    exp_q.push_back(v);
    tick();
    e = exp_q.pop_front();
    check(tag, q, e);
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 3'b000; din = v; start = 1'b0;
    step("load", v);
  endtask

  initial begin
    #3;
    check("rst_q", q, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_done", {7'b0, done}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    load(8'hA5);
    mode = 3'b011;
    for (int i = 0; i < 3; i++) step("hold", 8'hA5);
    check("soutl", {7'b0, soutl}, 8'h01);
    check("soutr", {7'b0, soutr}, 8'h01);
    load(8'h81); mode = 3'b001; sinl = 1'b0; step("shl", 8'h02);
    load(8'h81); mode = 3'b110; step("asr", 8'hC0);
    load(8'h81); mode = 3'b101; step("rotr", 8'hC0);
    load(8'h81); mode = 3'b010; sinr = 1'b1; step("shr", 8'hC0);
    load(8'h81); mode = 3'b100; step("rotl", 8'h03);
    load(8'h81); mode = 3'b111; step("hold7", 8'h81);
    load(8'h81); en = 1'b0; mode = 3'b000; din = 8'h3C; step("en0", 8'h81);
    // burst of 3 rotate-ups with distracting inputs on every busy edge
    load(8'h01);
    en = 1'b0; start = 1'b1; mode = 3'b100; nshift = 4'd3;
    step("acc_q", 8'h01);
    check("acc_busy", {7'b0, busy}, 8'h01);
    check("acc_done", {7'b0, done}, 8'h00);
    en = 1'b1; mode = 3'b000; din = 8'hFF; start = 1'b0;
    step("b1", 8'h02);
    start = 1'b1;
    step("b2", 8'h04);
    check("b2_done", {7'b0, done}, 8'h00);
    start = 1'b0; en = 1'b0;
    step("b3", 8'h08);
    check("b3_done", {7'b0, done}, 8'h01);
    check("b3_busy", {7'b0, busy}, 8'h01);
    start = 1'b1; mode = 3'b100; en = 1'b1;
    step("dn_q", 8'h08);
    check("dn_done", {7'b0, done}, 8'h00);
    check("dn_busy", {7'b0, busy}, 8'h00);
    start = 1'b0; en = 1'b0;
    // clamp: nshift=15 -> 8 rotates
    load(8'h96);
    en = 1'b0; start = 1'b1; mode = 3'b101; nshift = 4'd15;
    step("cl_acc", 8'h96);
    start = 1'b0;
    step("cl_r1", 8'h4B);
    for (int i = 0; i < 6; i++) tick();
    check("cl_r7_done", {7'b0, done}, 8'h00);
    check("cl_r7_busy", {7'b0, busy}, 8'h01);
    step("cl_r8", 8'h96);
    check("cl_done", {7'b0, done}, 8'h01);
    tick();
    check("cl_idle", {7'b0, busy}, 8'h00);
    // zero count: done pulse right after accept
    start = 1'b1; mode = 3'b001; nshift = 4'd0; sinl = 1'b1;
    step("z_q", 8'h96);
    check("z_done", {7'b0, done}, 8'h01);
    start = 1'b0;
    step("z_after", 8'h96);
    check("z_idle", {7'b0, busy}, 8'h00);
    // start with non-shift mode is ignored
    start = 1'b1; mode = 3'b011; nshift = 4'd4;
    step("ns_q", 8'h96);
    check("ns_busy", {7'b0, busy}, 8'h00);
    // async reset in the middle of a burst
    mode = 3'b100; nshift = 4'd5;
    step("ar_acc", 8'h96);
    start = 1'b0;
    step("ar_r1", 8'h2D);
    #2 reset = 1'b0;
    #1;
    check("ar_q", q, 8'h00);
    check("ar_busy", {7'b0, busy}, 8'h00);
    check("ar_done", {7'b0, done}, 8'h00);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) step("ar_post", 8'h00);
    check("ar_post_busy", {7'b0, busy}, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
